// File: rtl/conv_loop_gen.sv
// ---------------------------------------------------------------------------
// conv_loop_gen
// Nested-loop index generator for the conv engine. It walks
//   m (out channel) > r (out row) > c (out col) > n (in channel, step CH_STEP)
//   > i (kernel row) > j (kernel col)
// and presents one tuple per cycle on a valid/ready interface, with j as the
// innermost loop. Loop bounds are captured into shadow registers at start.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   start, abort        run control (start sampled in IDLE, abort in RUN)
//   cfg_k               kernel size K            (i, j in 0..K-1)
//   cfg_in_ch           input channel count      (n in 0, CH_STEP, ...)
//   cfg_out_size        output H=W size S        (r, c in 0..S-1)
//   cfg_out_ch          output channel count OC  (m in 0..OC-1)
//   out_valid/out_ready tuple handshake; the tuple is held while not ready
//   m, r, c, n, i, j    loop indices
//   last                current tuple is the final tuple of the run
//   busy                FSM not in IDLE
//   done                one-cycle pulse after the final tuple is accepted
//   cfg_err             one-cycle pulse when start is rejected (zero bound)
//
// Optional feature (macro ACC_CLR_EN):
//   acc_clr             first tuple of an output pixel (n, i, j all zero)
//   acc_wr              last tuple of an output pixel (final n, i, j)
//   Both are qualified by out_valid only; the consumer gates them with out_ready.
// ---------------------------------------------------------------------------
module conv_loop_gen #(
    parameter int KW      = 4,
    parameter int DW      = 8,
    parameter int CH_STEP = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [KW-1:0] cfg_k,
    input  logic [DW-1:0] cfg_in_ch,
    input  logic [DW-1:0] cfg_out_size,
    input  logic [DW-1:0] cfg_out_ch,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] m,
    output logic [DW-1:0] r,
    output logic [DW-1:0] c,
    output logic [DW-1:0] n,
    output logic [KW-1:0] i,
    output logic [KW-1:0] j,
    output logic          last,
    output logic          busy,
    output logic          done,
`ifdef ACC_CLR_EN
    output logic          acc_clr,
    output logic          acc_wr,
`endif
    output logic          cfg_err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [DW:0]   STEP_W  = (DW+1)'(CH_STEP);
    localparam logic [DW-1:0] STEP_DW = DW'(CH_STEP);

    state_t        state_q, state_d;
    logic [KW-1:0] k_q;
    logic [DW-1:0] in_ch_q, size_q, oc_q;

    logic          cfg_ok;
    logic          beat;
    logic [DW:0]   n_sum;
    logic          j_last, i_last, n_last, c_last, r_last, m_last;

    assign cfg_ok = (cfg_k != '0) && (cfg_in_ch != '0) &&
                    (cfg_out_size != '0) && (cfg_out_ch != '0);

    // n + CH_STEP is formed one bit wider so a bound near 2^DW cannot alias
    // to a small value; >= lets an IN_CH that is not a multiple of CH_STEP
    // still wrap on its final partial group.
    assign n_sum  = {1'b0, n} + STEP_W;
    assign j_last = (j == k_q - 1'b1);
    assign i_last = (i == k_q - 1'b1);
    assign n_last = (n_sum >= {1'b0, in_ch_q});
    assign c_last = (c == size_q - 1'b1);
    assign r_last = (r == size_q - 1'b1);
    assign m_last = (m == oc_q - 1'b1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and status outputs
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case leaves one unassigned and a latch is inferred.
        state_d   = state_q;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        last      = 1'b0;
        beat      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && cfg_ok) state_d = RUN;
            end
            RUN: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                last      = j_last && i_last && n_last && c_last && r_last && m_last;
                beat      = out_ready;
                // abort takes priority over a coincident final beat
                if (abort)             state_d = IDLE;
                else if (beat && last) state_d = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ACC_CLR_EN
    assign acc_clr = out_valid && (n == '0) && (i == '0) && (j == '0);
    assign acc_wr  = out_valid && n_last && i_last && j_last;
`endif

    // Shadow config, indices and the cfg_err pulse
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register here sees the pre-edge value of every other register.
        if (rst) begin
            k_q     <= '0;
            in_ch_q <= '0;
            size_q  <= '0;
            oc_q    <= '0;
            m       <= '0;
            r       <= '0;
            c       <= '0;
            n       <= '0;
            i       <= '0;
            j       <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= (state_q == IDLE) && start && !cfg_ok;
            if (state_q == IDLE && start && cfg_ok) begin
                k_q     <= cfg_k;
                in_ch_q <= cfg_in_ch;
                size_q  <= cfg_out_size;
                oc_q    <= cfg_out_ch;
                m <= '0; r <= '0; c <= '0; n <= '0; i <= '0; j <= '0;
            end else if (state_q == RUN) begin
                if (abort || (beat && last)) begin
                    // leaving RUN: indices are already zero in DONE/IDLE
                    m <= '0; r <= '0; c <= '0; n <= '0; i <= '0; j <= '0;
                end else if (beat) begin
                    if (j_last) begin
                        j <= '0;
                        if (i_last) begin
                            i <= '0;
                            if (n_last) begin
                                n <= '0;
                                if (c_last) begin
                                    c <= '0;
                                    if (r_last) begin
                                        r <= '0;
                                        m <= m + 1'b1;
                                    end else begin
                                        r <= r + 1'b1;
                                    end
                                end else begin
                                    c <= c + 1'b1;
                                end
                            end else begin
                                n <= n + STEP_DW;
                            end
                        end else begin
                            i <= i + 1'b1;
                        end
                    end else begin
                        j <= j + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_loop_gen.sv
// ---------------------------------------------------------------------------
// tb_conv_loop_gen
// Self-checking bench for conv_loop_gen. For each run the expected tuple
// sequence is built from plain nested loops and queued when the run is
// started; every accepted beat pops and compares one entry. Inputs change on
// the falling edge, outputs are sampled there too. Define ACC_CLR_EN to also
// check acc_clr/acc_wr.
// ---------------------------------------------------------------------------
module tb_conv_loop_gen;

    logic       clk = 1'b0;
    logic       rst, start, abort, out_ready;
    logic [3:0] cfg_k;
    logic [7:0] cfg_in_ch, cfg_out_size, cfg_out_ch;
    logic       out_valid, last, busy, done, cfg_err;
    logic [7:0] m_o, r_o, c_o, n_o;
    logic [3:0] i_o, j_o;
`ifdef ACC_CLR_EN
    logic       acc_clr, acc_wr;
`endif
    logic [39:0] dut_tup;

    int n_checks = 0;
    int n_errors = 0;
    logic [39:0] exp_q[$];

    always #5 clk = ~clk;

    assign dut_tup = {m_o, r_o, c_o, n_o, i_o, j_o};

    conv_loop_gen #(.KW(4), .DW(8), .CH_STEP(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_k(cfg_k), .cfg_in_ch(cfg_in_ch), .cfg_out_size(cfg_out_size),
        .cfg_out_ch(cfg_out_ch), .out_valid(out_valid), .out_ready(out_ready),
        .m(m_o), .r(r_o), .c(c_o), .n(n_o), .i(i_o), .j(j_o),
        .last(last), .busy(busy), .done(done),
`ifdef ACC_CLR_EN
        .acc_clr(acc_clr), .acc_wr(acc_wr),
`endif
        .cfg_err(cfg_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [39:0] tup(input int mm, rr, cc, nn, ii, jj);
        return {8'(mm), 8'(rr), 8'(cc), 8'(nn), 4'(ii), 4'(jj)};
    endfunction

    task automatic check_all_idle(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_last"},  last, 0);
        check({tag, "_tuple"}, dut_tup, 0);
    endtask

    // One run: queue the expected tuples, start, consume with optional
    // 1010 backpressure, optionally abort or reset on a given beat index.
    task automatic run_case(input int k, input int in_ch, input int s, input int oc,
                            input bit toggle, input int abort_at, input int rst_at);
        int          exp_n, beats, dones, stop_beat;
        bit          held_v, done_due, stopped;
        logic [39:0] held, e;
        exp_q.delete();
        for (int mm = 0; mm < oc; mm++)
            for (int rr = 0; rr < s; rr++)
                for (int cc = 0; cc < s; cc++)
                    for (int nn = 0; nn < in_ch; nn += 4)
                        for (int ii = 0; ii < k; ii++)
                            for (int jj = 0; jj < k; jj++)
                                exp_q.push_back(tup(mm, rr, cc, nn, ii, jj));
        exp_n = exp_q.size();

        @(negedge clk);
        cfg_k = 4'(k); cfg_in_ch = 8'(in_ch); cfg_out_size = 8'(s); cfg_out_ch = 8'(oc);
        start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // changes after start must not affect the run
        cfg_k = 4'd7; cfg_in_ch = 8'd3; cfg_out_size = 8'd9; cfg_out_ch = 8'd5;
        check("valid_latency", out_valid, 1);
        check("busy_run", busy, 1);

        beats = 0; dones = 0; held_v = 0; done_due = 0; stopped = 0; stop_beat = -1;
        held = '0;
        for (int cyc = 0; cyc < exp_n * 3 + 20; cyc++) begin
            if (done_due) begin
                check("done_after_last", done, 1);
                check("valid_in_done", out_valid, 0);
                done_due = 0;
            end
            if (done) dones++;
            if (held_v) check("stable_tuple", dut_tup, held);
            if (!busy && !out_valid) break;

            out_ready = toggle ? ~out_ready : 1'b1;
            start     = (beats == 2);  // ignored while RUN
            held_v    = out_valid && !out_ready;
            held      = dut_tup;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("tuple", dut_tup, e);
                    check("last", last, exp_q.size() == 0);
`ifdef ACC_CLR_EN
                    check("acc_clr", acc_clr, e[15:0] == 16'd0);
                    check("acc_wr", acc_wr, (int'(e[15:8]) + 4 >= in_ch) &&
                          (int'(e[7:4]) == k - 1) && (int'(e[3:0]) == k - 1));
`endif
                    if (beats == abort_at) abort = 1'b1;
                    if (beats == rst_at)   rst   = 1'b1;
                    if (abort || rst) stop_beat = beats;
                    done_due = (exp_q.size() == 0) && !abort && !rst;
                    beats++;
                end
            end
            @(negedge clk);
            if (abort || rst) begin
                abort = 1'b0; rst = 1'b0; start = 1'b0;
                check_all_idle("stop");
                check("stop_cfg_err", cfg_err, 0);
                repeat (3) begin
                    @(negedge clk);
                    check("no_done_after_stop", done, 0);
                    check("idle_after_stop", out_valid, 0);
                end
                stopped = 1;
                break;
            end
        end
        start = 1'b0;
        if (stopped) begin
            check("beats_before_stop", beats, stop_beat + 1);
        end else begin
            check("beat_count", beats, exp_n);
            check("done_count", dones, 1);
            check("idle_after_run", busy, 0);
            check_all_idle("post_run");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        cfg_k = '0; cfg_in_ch = '0; cfg_out_size = '0; cfg_out_ch = '0;
        repeat (3) @(negedge clk);
        check_all_idle("reset");
        check("reset_cfg_err", cfg_err, 0);
        rst = 1'b0;
        @(negedge clk);

        run_case(2, 8, 2, 1, 1'b0, -1, -1);   // n = 0,4; 32 beats
        run_case(3, 6, 1, 1, 1'b0, -1, -1);   // IN not multiple of step; 18 beats
        run_case(2, 8, 2, 1, 1'b1, -1, -1);   // 1010 backpressure
        run_case(5, 1, 4, 2, 1'b0, -1, -1);   // scaled-down K=5 sweep, 800 beats
        run_case(1, 1, 1, 1, 1'b0, -1, -1);   // single-tuple run
        run_case(1, 255, 1, 1, 1'b0, -1, -1); // n+4 crosses 2^DW
        run_case(2, 4, 1, 1, 1'b0, -1, -1);   // pixel boundaries for acc flags
        run_case(2, 8, 2, 1, 1'b0, 10, -1);   // abort on beat 10
        run_case(2, 8, 2, 1, 1'b0, 31, -1);   // abort coincident with last beat
        run_case(2, 8, 2, 1, 1'b1, -1, 5);    // reset mid-run

        // rejected starts: zero out-channel count, then zero kernel size
        @(negedge clk);
        cfg_k = 4'd2; cfg_in_ch = 8'd4; cfg_out_size = 8'd2; cfg_out_ch = 8'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("cfg_err_pulse", cfg_err, 1);
        check("cfg_err_no_valid", out_valid, 0);
        check("cfg_err_not_busy", busy, 0);
        @(negedge clk);
        check("cfg_err_one_cycle", cfg_err, 0);
        check("cfg_err_still_idle", out_valid, 0);
        cfg_k = 4'd0; cfg_out_ch = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("cfg_err_k0", cfg_err, 1);
        check("cfg_err_k0_no_valid", out_valid, 0);
        @(negedge clk);
        check("cfg_err_k0_clear", cfg_err, 0);

        // a good run still works after the rejects
        run_case(2, 8, 2, 1, 1'b0, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
